// File: rtl/decoder_nx_seq_if.sv
// decoder_nx_seq_if: handshake, control and result bus of the N-to-2^N decoder
interface decoder_nx_seq_if #(
    parameter int N  = 3,
    parameter int DW = 8
);
    localparam int W = 1 << N;
    logic          en;
    logic [1:0]    mode;
    logic          in_valid;
    logic [N-1:0]  in_code;
    logic          in_ready;
    logic [DW-1:0] dwell;
    logic [W-1:0]  y;
    logic [N-1:0]  code_out;
    logic          y_valid;
    modport master (output en, mode, in_valid, in_code, dwell, input in_ready, y, code_out, y_valid);
    modport slave  (input en, mode, in_valid, in_code, dwell, output in_ready, y, code_out, y_valid);
endinterface

// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered N-to-2^N decoder with one-hot/thermometer/active-low modes and a self-timed scan
module decoder_nx_seq #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input logic            clk,
    input logic            rst,
    decoder_nx_seq_if.slave bus
);
    localparam int W = 1 << N;
    localparam logic [W:0]   ONE = (W + 1)'(1);
    localparam logic [W-1:0] OH0 = W'(1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  y_q, y_d, dec_y;
    logic [N-1:0]  code_q, code_d, scan_q, scan_d, scan_inc;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          yv_q, yv_d;
    logic          scan_mode;
    logic [W:0]    one_sh, therm;
    assign scan_mode    = bus.mode == 2'b10;
    assign bus.in_ready = bus.en && !scan_mode;
    assign one_sh       = ONE << bus.in_code;
    assign therm        = (one_sh << 1) - ONE;
    assign dec_y        = bus.mode == 2'b00 ? one_sh[W-1:0] :
                          bus.mode == 2'b01 ? therm[W-1:0] : ~one_sh[W-1:0];
    assign scan_inc     = scan_q + 1'b1;
    assign bus.y        = y_q;
    assign bus.code_out = code_q;
    assign bus.y_valid  = yv_q;
    // State and datapath registers; everything clears asynchronously, including NDECODE output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            code_q  <= '0;
            scan_q  <= '0;
            cnt_q   <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            code_q  <= code_d;
            scan_q  <= scan_d;
            cnt_q   <= cnt_d;
            yv_q    <= yv_d;
        end
    end
    // Scan is active only while enabled cycles keep selecting SCAN; any other mode drops back to IDLE
    always_comb state_d = !bus.en ? state_q : (scan_mode ? RUN : IDLE);
    // Decode on accept, or walk the scan code with a dwell reloaded at every step
    always_comb begin
        y_d    = y_q;
        code_d = code_q;
        scan_d = scan_q;
        cnt_d  = cnt_q;
        yv_d   = 1'b0;
        if (bus.en && !scan_mode) begin
            scan_d = '0;
            cnt_d  = '0;
            if (bus.in_valid) begin
                y_d    = dec_y;
                code_d = bus.in_code;
                yv_d   = 1'b1;
            end
        end else if (bus.en && state_q == IDLE) begin
            y_d    = OH0;
            code_d = '0;
            scan_d = '0;
            cnt_d  = bus.dwell;
            yv_d   = 1'b1;
        end else if (bus.en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (bus.en) begin
            scan_d = scan_inc;
            y_d    = OH0 << scan_inc;
            code_d = scan_inc;
            cnt_d  = bus.dwell;
            yv_d   = 1'b1;
        end
    end
endmodule

// File: doc/decoder_nx_seq.md
Name: decoder_nx_seq

Overview:
Parametrised, registered N-to-2^N decoder. It is the next generation of the team's 3-to-8 combinational decoder. Adds:
- an input valid/ready handshake
- an enable
- thermometer and active-low decode modes
- an autonomous SCAN mode that walks every output in turn with a programmable dwell

Used for chip-select and row-strobe generation, and for LED/digit multiplexing.

Parameters:
N, 3, input code width; output width is 2^N.
DW, 8, dwell counter width for SCAN mode.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  global enable; low freezes all state.
mode  input  2  00 DECODE, 01 THERM, 10 SCAN, 11 NDECODE (active-low one-hot).
in_valid  input  1  in_code is valid this cycle.
in_code  input  N  code to decode; ignored in SCAN.
in_ready  output  1  block accepts in_code; combinational, = en && (mode != 10).
dwell  input  DW  SCAN hold length; each code is held dwell+1 enabled cycles.
y  output  2^N  registered decoded output.
code_out  output  N  registered code currently represented on y.
y_valid  output  1  one-cycle pulse when y/code_out take a new value.

Behaviour:
- Asynchronous reset (rst high) forces, immediately and for as long as rst is held:
  - y = 0, code_out = 0, y_valid = 0
  - scan_active = 0, scan_code = 0, dwell_cnt = 0
- Reset applies in every mode, including NDECODE (y = all-zeros, not all-ones). Reset mid-scan abandons the scan; the first enabled SCAN cycle after release restarts at code 0.
- All state updates happen on the rising edge of clk only when en = 1.
- en = 0:
  - y, code_out, scan_code and dwell_cnt hold their values
  - y_valid = 0 on the next edge
  - in_ready = 0
- Accept = en && in_valid && in_ready. On accept, at the next edge (latency 1), with c = in_code:
  - DECODE: y <= 1 << c.
  - THERM: y <= (2 << c) - 1, i.e. bits 0..c set. c = 2^N-1 gives all ones.
  - NDECODE: y <= ~(1 << c).
  - In all three modes: code_out <= c, y_valid <= 1.
- Enabled cycle with no accept: y and code_out hold, y_valid <= 0.
- SCAN (mode = 10), enabled cycles only; in_valid and in_code are ignored:
  - State IDLE (scan_active = 0): on the edge, y <= onehot(0), code_out <= 0, y_valid <= 1, dwell_cnt <= dwell, go to RUN.
  - State RUN, dwell_cnt != 0: dwell_cnt decrements, y_valid <= 0.
  - State RUN, dwell_cnt == 0: scan_code <= scan_code + 1, wrapping 2^N-1 -> 0. Also y <= onehot(new code), code_out <= new code, y_valid <= 1, dwell_cnt <= dwell.
  - dwell is sampled only at each load; changing it mid-dwell takes effect at the next step.
  - Resulting period is dwell+1 enabled cycles per code.
- Mode change:
  - Any enabled cycle with mode != 10 clears scan_active, scan_code and dwell_cnt. Re-entering SCAN restarts at code 0.
  - Leaving SCAN with no accept leaves y/code_out holding the last scanned value.
  - Mode is sampled per cycle; an accept decodes according to the mode on that same edge.
- Widths:
  - Shifts are computed at 2^N+1 bits and truncated to 2^N.
  - The scan code increment is N bits with natural wrap.
  - The dwell decrement never underflows: the load happens at 0.

Test Plan:
1. Reset/DECODE, N=3: assert rst mid-cycle -> y=00000000, y_valid=0 immediately. Release, mode=00, en=1, in_valid=1, in_code=0..7 one per cycle -> one cycle later y=00000001..10000000, code_out tracks the code, y_valid high each cycle.
2. THERM/NDECODE: mode=01, in_code=3 -> y=00001111; in_code=7 -> y=11111111. Then mode=11, in_code=5 -> y=11011111. Then in_valid=0 for 3 cycles -> y holds 11011111, y_valid=0.
3. SCAN wrap: mode=10, dwell=2 -> y=00000001 for 3 cycles, then 00000010 …, 10000000, then back to 00000001 after 24 cycles. y_valid pulses every 3rd cycle. in_ready=0 throughout; in_valid pulses are ignored.
4. SCAN freeze/dwell change: during SCAN at code 4 with dwell_cnt=1, drop en for 5 cycles -> y and code_out frozen, no y_valid. Restore en -> remaining dwell completes. Set dwell=0 mid-dwell -> current code keeps its loaded dwell, after which codes advance every cycle.
5. Mode switch and reset mid-scan: scan to code 5, switch to mode=00 with in_code=2 -> y=00000100. Return to mode=10 -> restarts at 00000001. Scan to code 6, pulse rst -> all zero; first enabled SCAN cycle after release -> y=00000001, code_out=0.
6. Parameter sweep N=1 and N=5, DW=4: DECODE of the max code -> top bit set only. SCAN with dwell=15 -> each code is held 16 cycles and the scan wraps after 2^N codes.
